// File: rtl/sim_sdram_burst_model_if.sv
// Command/data bus between an SDRAM client (master) and the burst model (slave).
interface sim_sdram_burst_model_if #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 25
);
  logic [1:0]             command;
  logic [AddrWidth-1:0]   address;
  logic [DataWidth-1:0]   write_data;
  logic [DataWidth/8-1:0] write_mask;
  logic                   cmd_ready;
  logic                   write_data_req;
  logic                   write_done;
  logic [DataWidth-1:0]   read_data;
  logic                   read_data_valid;
  logic                   refresh_active;
  logic                   busy;

  modport master (
    output command, address, write_data, write_mask,
    input  cmd_ready, write_data_req, write_done, read_data, read_data_valid,
           refresh_active, busy
  );

  modport slave (
    input  command, address, write_data, write_mask,
    output cmd_ready, write_data_req, write_done, read_data, read_data_valid,
           refresh_active, busy
  );
endinterface

// File: rtl/sim_sdram_burst_model.sv
// Cycle-approximate SDR SDRAM model behind a simple command front-end.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | ready for a command unless a refresh is pending
// S_ACTIVATE | row open delay (Trcd cycles)
// S_WRITE    | one write beat consumed per cycle
// S_READ     | one read beat issued per cycle into the CAS pipeline
// S_PRECHARGE| row close delay (Trp cycles)
// S_REFRESH  | refresh stall (RefreshCycles cycles)
module sim_sdram_burst_model #(
  parameter int DataWidth       = 16,
  parameter int BankBits        = 2,
  parameter int RowBits         = 13,
  parameter int ColBits         = 10,
  parameter int MemDepthBits    = 16,
  parameter int BurstLength     = 8,
  parameter int WriteBurst      = 1,
  parameter int CasLatency      = 3,
  parameter int Trcd            = 3,
  parameter int Trp             = 3,
  parameter int RefreshInterval = 1100,
  parameter int RefreshCycles   = 9
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  sim_sdram_burst_model_if.slave bus
);

  localparam int AddrWidth  = BankBits + RowBits + ColBits;
  localparam int NumBytes   = DataWidth / 8;
  localparam int WriteBeats = (WriteBurst != 0) ? BurstLength : 1;
  localparam int BeatW      = (BurstLength > 1) ? $clog2(BurstLength) : 1;
  localparam int RefW       = $clog2(RefreshInterval);
  localparam logic [ColBits-1:0] BurstMask = ColBits'(BurstLength - 1);

  if (BurstLength != 1 && BurstLength != 2 && BurstLength != 4 && BurstLength != 8) begin : g_bad_bl
    $error("BurstLength must be 1, 2, 4 or 8");
  end
  if (CasLatency != 2 && CasLatency != 3) begin : g_bad_cl
    $error("CasLatency must be 2 or 3");
  end
  if (Trcd < 1 || Trp < 1 || RefreshCycles < 1) begin : g_bad_timing
    $error("Trcd, Trp and RefreshCycles must be at least 1");
  end
  if (RefreshInterval <= Trcd + BurstLength + Trp + RefreshCycles + 1) begin : g_bad_ref
    $error("RefreshInterval too short for one burst plus refresh");
  end
  if (DataWidth % 8 != 0 || MemDepthBits > AddrWidth) begin : g_bad_width
    $error("DataWidth must be a byte multiple and MemDepthBits must not exceed the address width");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ACTIVATE, S_WRITE, S_READ, S_PRECHARGE, S_REFRESH
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            timer_q, timer_d;
  logic [BeatW-1:0]       beat_q, beat_d;
  logic [AddrWidth-1:0]   addr_q;
  logic                   op_write_q;
  logic [RefW-1:0]        refresh_cnt_q;
  logic                   refresh_pending_q;
  logic                   write_done_q;
  logic [CasLatency-1:0]  rd_valid_q;
  logic [DataWidth-1:0]   rd_data_q [CasLatency];
  logic [DataWidth-1:0]   mem_q [2**MemDepthBits];

  logic                   accept;
  logic                   refresh_wrap;
  logic                   refresh_clear;
  logic                   rd_issue;
  logic [ColBits-1:0]     beat_col;
  logic [MemDepthBits-1:0] mem_idx;

  assign accept        = (state_q == S_IDLE) && !refresh_pending_q &&
                         (bus.command == 2'd1 || bus.command == 2'd2);
  assign refresh_wrap  = (refresh_cnt_q == RefW'(RefreshInterval - 1));
  assign refresh_clear = (state_q == S_REFRESH) && (timer_q == '0);
  assign rd_issue      = (state_q == S_READ);

  // Sequential wrap inside the aligned burst; bank and row stay fixed, upper bits alias.
  assign beat_col = (addr_q[ColBits-1:0] & ~BurstMask) |
                    ((addr_q[ColBits-1:0] + ColBits'(beat_q)) & BurstMask);
  assign mem_idx  = MemDepthBits'({addr_q[AddrWidth-1:ColBits], beat_col});

  // FSM state, phase timer and beat counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic; every timed phase counts down to zero then moves on.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    beat_d  = beat_q;
    unique case (state_q)
      S_IDLE: begin
        if (refresh_pending_q) begin
          state_d = S_REFRESH;
          timer_d = 16'(RefreshCycles - 1);
        end else if (accept) begin
          state_d = S_ACTIVATE;
          timer_d = 16'(Trcd - 1);
        end
      end
      S_ACTIVATE: begin
        if (timer_q == '0) begin
          state_d = op_write_q ? S_WRITE : S_READ;
          timer_d = op_write_q ? 16'(WriteBeats - 1) : 16'(BurstLength - 1);
          beat_d  = '0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_WRITE, S_READ: begin
        if (timer_q == '0) begin
          state_d = S_PRECHARGE;
          timer_d = 16'(Trp - 1);
        end else begin
          timer_d = timer_q - 16'd1;
          beat_d  = beat_q + BeatW'(1);
        end
      end
      S_PRECHARGE, S_REFRESH: begin
        if (timer_q == '0) state_d = S_IDLE;
        else               timer_d = timer_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Latch address and operation of an accepted command; flag the end of a write burst.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q       <= '0;
      op_write_q   <= 1'b0;
      write_done_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= bus.address;
        op_write_q <= (bus.command == 2'd1);
      end
      write_done_q <= (state_q == S_WRITE) && (timer_q == '0);
    end
  end

  // Free-running refresh interval counter; a wrap raises a pending refresh.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      refresh_cnt_q     <= '0;
      refresh_pending_q <= 1'b0;
    end else begin
      refresh_cnt_q <= refresh_wrap ? '0 : refresh_cnt_q + RefW'(1);
      if (refresh_wrap)       refresh_pending_q <= 1'b1;
      else if (refresh_clear) refresh_pending_q <= 1'b0;
    end
  end

  // Byte-masked storage write; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (state_q == S_WRITE) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (!bus.write_mask[b]) mem_q[mem_idx][b*8 +: 8] <= bus.write_data[b*8 +: 8];
      end
    end
  end

  // CAS pipeline: data captured at issue, drains regardless of FSM state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= '0;
      for (int i = 0; i < CasLatency; i++) rd_data_q[i] <= '0;
    end else begin
      rd_valid_q[0] <= rd_issue;
      rd_data_q[0]  <= rd_issue ? mem_q[mem_idx] : '0;
      for (int i = 1; i < CasLatency; i++) begin
        rd_valid_q[i] <= rd_valid_q[i-1];
        rd_data_q[i]  <= rd_data_q[i-1];
      end
    end
  end

  assign bus.cmd_ready       = (state_q == S_IDLE) && !refresh_pending_q;
  assign bus.write_data_req  = (state_q == S_WRITE);
  assign bus.write_done      = write_done_q;
  assign bus.read_data       = rd_data_q[CasLatency-1];
  assign bus.read_data_valid = rd_valid_q[CasLatency-1];
  assign bus.refresh_active  = (state_q == S_REFRESH);
  assign bus.busy            = (state_q != S_IDLE);

endmodule

// File: doc/sim_sdram_burst_model.md
Name: sim_sdram_burst_model

Overview:
- Parametrised, cycle-approximate behavioural model of a single-data-rate SDRAM, seen through a simple command front-end.
- Used in simulation in place of the board SDRAM controller, so upstream logic (weight/image loaders) sees realistic latencies.
- Models activate (tRCD), CAS latency, wrapping sequential bursts, byte masking, precharge (tRP) and periodic refresh stalls.
- Provides a ready/request handshake that the fixed-latency predecessor lacked.

Parameters:
DataWidth, 16, data bus width; multiple of 8
BankBits, 2, bank address bits
RowBits, 13, row address bits
ColBits, 10, column address bits
MemDepthBits, 16, implemented storage words = 2**MemDepthBits; storage is indexed by the low MemDepthBits bits of {bank,row,col}; upper bits alias
BurstLength, 8, 1/2/4/8; other values fail an elaboration assertion
WriteBurst, 1, 1 = burst write of BurstLength beats; 0 = single-beat write
CasLatency, 3, 2 or 3; read-issue-to-data cycles
Trcd, 3, activate cycles, >=1
Trp, 3, precharge cycles, >=1
RefreshInterval, 1100, cycles between refresh requests
RefreshCycles, 9, cycles per refresh, >=1

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
command_i  in  2  0 idle, 1 write, 2 read, 3 reserved (ignored)
address_i  in  BankBits+RowBits+ColBits  {bank,row,col}; sampled on accept
write_data_i  in  DataWidth  write beat; sampled in each cycle write_data_req_o=1
write_mask_i  in  DataWidth/8  per-byte mask; 1 = byte not written
cmd_ready_o  out  1  command accepted this cycle if high and command_i is 1 or 2
write_data_req_o  out  1  current cycle consumes one write beat
write_done_o  out  1  one-cycle pulse after the last write beat
read_data_o  out  DataWidth  read beat
read_data_valid_o  out  1  read_data_o valid
refresh_active_o  out  1  high while refreshing
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async assert): state IDLE, refresh counter 0, refresh_pending 0, read pipeline cleared. All outputs 0 except cmd_ready_o. Storage contents are not reset. Beats written before reset persist.
- States: IDLE, ACTIVATE, WRITE, READ, PRECHARGE, REFRESH.
- cmd_ready_o = (state==IDLE) && !refresh_pending. Commands presented while not ready, and command 3, are dropped; nothing is queued.
- Accept at cycle T: latch address and operation, then go to ACTIVATE.
- ACTIVATE occupies T+1..T+Trcd, then goes to WRITE or READ.
- WRITE: write_data_req_o high for N beats (N = BurstLength if WriteBurst else 1), cycles T+Trcd+1..T+Trcd+N.
  - Each unmasked byte of write_data_i is stored in the same cycle.
  - write_done_o pulses in the cycle after the last beat, as PRECHARGE begins.
- READ: beat k (0..BurstLength-1) is issued in cycle T+Trcd+1+k. read_data_valid_o/read_data_o for beat k appear at issue+CasLatency.
  - Valid beats are contiguous.
  - The pipeline drains independently of the FSM.
- Burst addressing is sequential and wraps within the aligned burst. Beat k column = (col & ~(BL-1)) | ((col+k) & (BL-1)). Bank and row are unchanged.
- PRECHARGE lasts Trp cycles, then goes to IDLE.
  - A new read may be accepted while the previous read's data is still draining.
  - Read data always reflects storage at issue time.
- Refresh:
  - The counter increments every cycle and wraps at RefreshInterval-1; on wrap it sets refresh_pending.
  - In IDLE, pending refresh has priority over a simultaneous command: the command is not accepted (cmd_ready_o already low).
  - REFRESH lasts RefreshCycles with refresh_active_o high, then pending clears and the FSM returns to IDLE.
  - Elaboration assertion: RefreshInterval > Trcd+BurstLength+Trp+RefreshCycles+1.
- Reset mid-operation aborts the burst. read_data_valid_o drops immediately and never presents stale beats after release. cmd_ready_o is high in the first cycle after release.

Test Plan:
- Burst write/read (BL=8, CL=3, Trcd=3, Trp=3, WriteBurst=1): write 0x1111..0x8888 to col 0x00A, accepted at T.
  - write_data_req_o is high T+4..T+11, and write_done_o pulses at T+12.
  - A read of col 0x00A returns 0x1111..0x8888 with the first valid at accept+7.
  - Storage order is cols A,B,C,D,E,F,8,9.
- WriteBurst=0: prefill 0x0000 over cols 0x10-0x17, then write 0xBEEF to col 0x13.
  - write_data_req_o is high exactly 1 cycle.
  - A burst read from col 0x10 returns 0,0,0,0xBEEF,0,0,0,0.
- Byte mask: store 0x1234, then write 0xABCD with mask 2'b10 -> read returns 0x12CD.
- Refresh (RefreshInterval=100, RefreshCycles=9): hold a read command across the refresh point.
  - cmd_ready_o is low and refresh_active_o high for 9 cycles.
  - The read is accepted on the following cycle with correct data.
- Busy drop: present a write during an active read -> no write_data_req_o, and storage is unchanged on re-read.
- Reset mid-read: drive rst_ni low after 2 valid beats.
  - read_data_valid_o goes 0 immediately and stays 0 after release.
  - cmd_ready_o is 1 in the first post-release cycle.
